// File: rtl/dm_pipe_if.sv
// Request/response bus between the MEM stage (master) and the data memory (slave).
// Handshake: a request is accepted on a rising edge where req=1 and ready=1; the master must hold
// req/we/addr/wdata/be stable until that edge. The response is a single-cycle rvalid strobe that
// qualifies rdata and err; the master has no back-pressure on the response.
interface dm_pipe_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic                  req;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   be;
    logic                  ready;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;
    logic                  err;

    modport master (
        output req, we, addr, wdata, be,
        input  ready, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ready, rvalid, rdata, err
    );
endinterface

// File: rtl/dm_pipe.sv
// Data memory with request/response handshake, programmable wait states, byte-lane writes
// and out-of-range detection. Words 0 and 1 are reloaded with fixed values on reset.
module dm_pipe #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1,
    parameter logic [DATA_W-1:0] INIT0 = DATA_W'(8),
    parameter logic [DATA_W-1:0] INIT1 = DATA_W'(5)
) (
    input  logic        clk,
    input  logic        reset,
    dm_pipe_if.slave    bus,
    output logic [1:0]  dbg_state
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state, next_state;
    logic [3:0]          cnt;
    logic                ready, accept, enter_resp;

    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [NB-1:0]       lat_be;

    logic                acc_we;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdata;
    logic [NB-1:0]       acc_be;
    logic                in_range;
    logic [IDX_W-1:0]    idx;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic                rvalid_q, err_q;
    logic [DATA_W-1:0]   rdata_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_RESP: begin
                if (accept) next_state = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                else        next_state = S_IDLE;
            end
            S_WAIT:  if (cnt == 4'd0) next_state = S_RESP;
            default: next_state = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ready      = !reset && (state == S_IDLE || state == S_RESP);
        accept     = bus.req && ready;
        enter_resp = !reset && (next_state == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 4'd0;
        end else if (accept) begin
            lat_we    <= bus.we;
            lat_addr  <= bus.addr;
            lat_wdata <= bus.wdata;
            lat_be    <= bus.be;
            cnt       <= CNT_LOAD;
        end else if (state == S_WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // With zero wait states the access happens on the accept edge, before the latches hold the request.
    always_comb begin
        acc_we    = accept ? bus.we    : lat_we;
        acc_addr  = accept ? bus.addr  : lat_addr;
        acc_wdata = accept ? bus.wdata : lat_wdata;
        acc_be    = accept ? bus.be    : lat_be;
        in_range  = {1'b0, acc_addr} < DEPTH_X;
        idx       = acc_addr[IDX_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            mem[0]   <= INIT0;
            mem[1]   <= INIT1;
        end else begin
            rvalid_q <= enter_resp;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            if (enter_resp) begin
                err_q <= !in_range;
                if (in_range) begin
                    if (acc_we) begin
                        for (int i = 0; i < NB; i++) begin
                            if (acc_be[i]) mem[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                        end
                    end else begin
                        rdata_q <= mem[idx];
                    end
                end
            end
        end
    end

    assign bus.ready  = ready;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;
    assign bus.err    = err_q;
    assign dbg_state  = state;
endmodule

// File: doc/dm_pipe.md
Name: dm_pipe

Overview:
Parametrised data memory with a request/response handshake, programmable wait states, byte-lane write enables and out-of-range detection. It replaces the fixed 16-bit single-cycle data memory in the MEM stage. The pipeline issues one request and stalls on `ready` until the response. Memory words 0 and 1 are loaded with fixed init values on reset.

Parameters:
- DATA_W, 16, data width in bits; must be a multiple of 8.
- ADDR_W, 16, address port width in bits.
- DEPTH, 256, number of words; valid addresses are 0..DEPTH-1.
- WAIT_STATES, 1, extra cycles between accept and response (0..15).
- INIT0, 8, value loaded into word 0 on reset.
- INIT1, 5, value loaded into word 1 on reset.

Ports:
- clk, input, 1, clock; all logic is on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- req, input, 1, request valid.
- we, input, 1, 1 = write, 0 = read; sampled on accept.
- addr, input, ADDR_W, word address; sampled on accept.
- wdata, input, DATA_W, write data; sampled on accept.
- be, input, DATA_W/8, byte-lane enables for writes; sampled on accept.
- ready, output, 1, the block can accept a request this cycle.
- rvalid, output, 1, one-cycle response strobe; asserted for reads and writes.
- rdata, output, DATA_W, read data; valid only while rvalid=1.
- err, output, 1, out-of-range flag; valid only while rvalid=1.

Behaviour:
- Reset: clk and reset are the codebase port names. Reset is synchronous and active-high.
  - While reset=1 at an edge: state becomes IDLE, rvalid=0, rdata=0, err=0, wait counter=0.
  - mem[0] is loaded with INIT0 and mem[1] with INIT1. All other words keep their contents.
  - ready=0 while reset is high.
- FSM states: IDLE, WAIT, RESP.
- ready is combinational: 1 in IDLE or RESP, 0 in WAIT or during reset.
- Accept: req & ready at edge T latches we, addr, wdata and be.
  - If WAIT_STATES=0, next state is RESP.
  - Otherwise next state is WAIT, with counter loaded to WAIT_STATES-1.
- WAIT: the counter decrements each cycle. On the edge where counter=0, the state moves to RESP.
- Access timing: the memory access happens on the edge that enters RESP, so rvalid=1 during cycle T+1+WAIT_STATES.
- Write: each lane i with be[i]=1 updates bits [8i+7:8i]; disabled lanes are unchanged. rdata=0 on write responses.
- Read: rdata is the full word at the latched address.
- Range check: the full ADDR_W value of addr is compared against DEPTH. The index uses the low clog2(DEPTH) bits.
- Out of range (addr >= DEPTH): no memory write, rdata=0, err=1 together with rvalid.
- In range: err=0.
- RESP lasts exactly one cycle:
  - If req=1 in RESP, the new request is accepted (back-to-back) and the FSM goes to WAIT/RESP as from IDLE.
  - Otherwise the FSM goes to IDLE, and rvalid, rdata and err return to 0.
- Read-after-write ordering: a write commits before its rvalid. A read accepted during or after that RESP cycle returns the new data.
- req while in WAIT is ignored (ready=0). The requester must hold req and its fields until accepted.
- Reset mid-transaction: the transaction is aborted, no response is issued, and a pending write is not committed.
- Throughput: one access per WAIT_STATES+1 cycles when req is held high.

Test Plan:
- Reset, then read addr 0 and addr 1 (WAIT_STATES=1): rdata=8 then 5; err=0; each rvalid arrives 2 cycles after its accept.
- Write 0xBEEF to addr 7 with be=2'b11, then read addr 7: write ack rvalid has rdata=0; read returns 0xBEEF; ready is low during the WAIT cycle.
- Write 0x1234 to addr 7 with be=2'b01, then read addr 7: returns 0xBE34.
- Write to addr 300 with DEPTH=256, then read addr 300 and addr 44 (44 = 300 mod 256): both responses to addr 300 have rvalid=1, err=1, rdata=0; addr 44 is unchanged.
- req held high with a write to addr 3 followed by a read of addr 3, WAIT_STATES=0: the second accept happens in the RESP cycle of the first, rvalid is high on consecutive cycles, and the read returns the written data.
- Write addr 9 = 0x5555, then assert reset during the WAIT cycle and read addr 9 after reset: no rvalid is issued for the write; addr 9 holds its old value; mem[0]=8 and mem[1]=5 are restored.
